dual_port_ram_lat: RTL
======================

DUAL_PORT_RAM_LAT -- requirements
Module: dual_port_ram_lat

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
  ADDRESS_WIDTH    8   address bits per port; depth = 2**ADDRESS_WIDTH
  DATA_WIDTH       8   word width
  WRITE_LATENCY_A  1   port A request-to-execute latency in clocks, legal 1..8
  WRITE_LATENCY_B  1   port B request-to-execute latency in clocks, legal 1..8
  READ_LATENCY     1   execute-to-o_dout latency in clocks, both ports, legal 1..4
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
  i_clk        in   1              single clock; all logic on posedge
  i_rst_n      in   1              reset, asynchronous, active-low
  i_addr_a     in   ADDRESS_WIDTH  port A address
  i_en_a       in   1              port A request enable
  i_we_a       in   1              port A write enable; qualified by i_en_a
  i_din_a      in   DATA_WIDTH     port A write data
  o_dout_a     out  DATA_WIDTH     port A read data
  o_valid_a    out  1              port A read data valid strobe
  i_addr_b, i_en_b, i_we_b, i_din_b, o_dout_b, o_valid_b   same as port A, for port B
  o_collision  out  1              write-write collision strobe

Function
REQ-003 Each port SHALL sample {addr, en, we, din} on every posedge into a request delay line of WRITE_LATENCY_x-1 register stages.
REQ-004 A request sampled at edge k SHALL execute at the array at edge k+WRITE_LATENCY_x-1. With WRITE_LATENCY_x=1, execution SHALL occur at edge k with no delay stage.
REQ-005 An executing request with en=1, we=1 SHALL write din to mem[addr].
REQ-006 An executing request with en=1, we=0 SHALL read mem[addr] into a read pipeline of READ_LATENCY stages.
REQ-007 Read data SHALL appear on o_dout_x with o_valid_x=1 exactly READ_LATENCY clocks after the execute edge. Total request-to-data latency SHALL be WRITE_LATENCY_x-1+READ_LATENCY clocks.
REQ-008 o_valid_x SHALL be a one-clock strobe per read. o_dout_x SHALL hold its last read value while o_valid_x=0.
REQ-009 Writes SHALL produce no o_valid_x strobe and SHALL leave o_dout_x unchanged.
REQ-010 A request with en=0 SHALL be a no-op. we and din SHALL be ignored while en=0.
REQ-011 Back-to-back requests on every clock SHALL be accepted with no stalls. Throughput SHALL be one operation per port per clock.
REQ-012 Same-edge read and write to the same address, on the same or the opposite port, SHALL be read-first: the read returns the old contents.
REQ-013 Both ports writing the same address at the same execute edge SHALL result in port A's data being stored, and o_collision SHALL pulse high for the following clock only.
REQ-014 Execute edges are compared, not request edges: with unequal WRITE_LATENCY_A and WRITE_LATENCY_B, collision and read-first SHALL be judged at the execute edge.
REQ-015 Addresses SHALL cover the full 0..2**ADDRESS_WIDTH-1 range with no wrap or aliasing logic.
REQ-016 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-017 While i_rst_n=0, regardless of clock, all delay-line and read-pipeline stages SHALL be cleared to en=0 and o_dout_a=o_dout_b=0, o_valid_a=o_valid_b=0, o_collision=0.
REQ-018 Array contents SHALL NOT be reset. Requests in flight at reset assertion SHALL be discarded: no write is performed and no o_valid is produced.
REQ-019 The first posedge after i_rst_n deasserts SHALL sample a new request normally.

Verification
REQ-020 WLA=1, RL=1: write A addr 0x10 data 0x5A at edge k; read A 0x10 at edge k+1 -> o_dout_a=0x5A, o_valid_a=1 after edge k+2 for one clock.
REQ-021 WLA=3, WLB=1, RL=2: write A 0x20=0x11 at edge k; read B 0x20 at edge k+2 (same execute edge) -> o_dout_b returns the old value (read-first); read B at edge k+3 -> 0x11.
REQ-022 Write A 0x30=0xAA and write B 0x30=0xBB at the same execute edge -> o_collision=1 for one clock; later read of 0x30 returns 0xAA.
REQ-023 Continuous alternating write/read on both ports for 256 clocks against a scoreboard -> every o_valid strobe arrives at the exact latency with the correct data and no stall.
REQ-024 WLA=4: issue write A 0x40=0x77 then assert i_rst_n=0 mid-clock before execute -> all outputs 0 immediately; after reset, read 0x40 does not return 0x77 (value unchanged from before the write).
REQ-025 i_en_a=0 with i_we_a=1 and i_din_a=0xFF at 0x50 -> mem[0x50] unchanged, no o_valid_a strobe.

Source files
------------

// File: rtl/dual_port_ram_lat.sv
// dual_port_ram_lat: two-port RAM. Each port delays its requests through a
// WRITE_LATENCY_x-1 stage line before they reach the array. The array is
// read-first, and port A wins a same-address write collision. Read data passes
// through READ_LATENCY stages before it reaches o_dout_x.
`timescale 1ns/1ps
module dual_port_ram_lat #(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int WRITE_LATENCY_A = 1,
    parameter int WRITE_LATENCY_B = 1,
    parameter int READ_LATENCY    = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [ADDRESS_WIDTH-1:0] i_addr_a,
    input  logic                     i_en_a,
    input  logic                     i_we_a,
    input  logic [DATA_WIDTH-1:0]    i_din_a,
    output logic [DATA_WIDTH-1:0]    o_dout_a,
    output logic                     o_valid_a,
    input  logic [ADDRESS_WIDTH-1:0] i_addr_b,
    input  logic                     i_en_b,
    input  logic                     i_we_b,
    input  logic [DATA_WIDTH-1:0]    i_din_b,
    output logic [DATA_WIDTH-1:0]    o_dout_b,
    output logic                     o_valid_b,
    output logic                     o_collision
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int DL_A  = WRITE_LATENCY_A - 1;
    localparam int DL_B  = WRITE_LATENCY_B - 1;

    typedef struct packed {
        logic                     en;
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    din;
    } req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } rd_t;

    // Reject unsupported configurations while elaborating.
    generate
        if (ADDRESS_WIDTH < 1 || DATA_WIDTH < 1) begin : g_err_width
            $error("dual_port_ram_lat: ADDRESS_WIDTH and DATA_WIDTH must be >= 1");
        end
        if (WRITE_LATENCY_A < 1 || WRITE_LATENCY_A > 8) begin : g_err_wla
            $error("dual_port_ram_lat: WRITE_LATENCY_A must be in 1..8");
        end
        if (WRITE_LATENCY_B < 1 || WRITE_LATENCY_B > 8) begin : g_err_wlb
            $error("dual_port_ram_lat: WRITE_LATENCY_B must be in 1..8");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_err_rl
            $error("dual_port_ram_lat: READ_LATENCY must be in 1..4");
        end
    endgenerate

    req_t req_in_a, req_in_b;
    req_t exec_a, exec_b;

    assign req_in_a = {i_en_a, i_we_a, i_addr_a, i_din_a};
    assign req_in_b = {i_en_b, i_we_b, i_addr_b, i_din_b};

    // Port A request delay line. A latency of 1 feeds the array directly.
    generate
        if (DL_A == 0) begin : g_dl_a_none
            assign exec_a = req_in_a;
        end else begin : g_dl_a
            req_t dl_q [DL_A];
            req_t dl_d [DL_A];

            // Shift port A requests one stage per clock.
            always_comb begin
                dl_d[0] = req_in_a;
                for (int i = 1; i < DL_A; i++) dl_d[i] = dl_q[i-1];
            end

            // Port A delay-line registers. Reset drops every in-flight request.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                // NOTE: sequential state uses non-blocking assignments, so every stage samples pre-edge values.
                if (!i_rst_n) begin
                    for (int i = 0; i < DL_A; i++) dl_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DL_A; i++) dl_q[i] <= dl_d[i];
                end
            end

            assign exec_a = dl_q[DL_A-1];
        end
    endgenerate

    // Port B request delay line. A latency of 1 feeds the array directly.
    generate
        if (DL_B == 0) begin : g_dl_b_none
            assign exec_b = req_in_b;
        end else begin : g_dl_b
            req_t dl_q [DL_B];
            req_t dl_d [DL_B];

            // Shift port B requests one stage per clock.
            always_comb begin
                dl_d[0] = req_in_b;
                for (int i = 1; i < DL_B; i++) dl_d[i] = dl_q[i-1];
            end

            // Port B delay-line registers. Reset drops every in-flight request.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DL_B; i++) dl_q[i] <= '0;
                end else begin
                    for (int i = 0; i < DL_B; i++) dl_q[i] <= dl_d[i];
                end
            end

            assign exec_b = dl_q[DL_B-1];
        end
    endgenerate

    logic wr_a, wr_b, rd_a, rd_b;

    assign wr_a = exec_a.en &  exec_a.we;
    assign rd_a = exec_a.en & ~exec_a.we;
    assign wr_b = exec_b.en &  exec_b.we;
    assign rd_b = exec_b.en & ~exec_b.we;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Array writes. B is assigned first so that A's data survives a same-address collision.
    always_ff @(posedge i_clk) begin
        // NOTE: the array has no reset, because its contents must survive reset. Reads capture it in the same edge before these updates land, which makes the array read-first.
        if (wr_b) mem_q[exec_b.addr] <= exec_b.din;
        if (wr_a) mem_q[exec_a.addr] <= exec_a.din;
    end

    rd_t                   rp_a_q [READ_LATENCY];
    rd_t                   rp_a_d [READ_LATENCY];
    rd_t                   rp_b_q [READ_LATENCY];
    rd_t                   rp_b_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic                  valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic                  collision_q, collision_d;

    // Next state for the read pipelines, the held outputs and the collision strobe.
    always_comb begin
        // NOTE: every variable is assigned on every pass, so no latch can be inferred.
        rp_a_d[0] = {rd_a, mem_q[exec_a.addr]};
        rp_b_d[0] = {rd_b, mem_q[exec_b.addr]};
        for (int i = 1; i < READ_LATENCY; i++) begin
            rp_a_d[i] = rp_a_q[i-1];
            rp_b_d[i] = rp_b_q[i-1];
        end
        valid_a_d   = rp_a_q[READ_LATENCY-1].valid;
        valid_b_d   = rp_b_q[READ_LATENCY-1].valid;
        dout_a_d    = valid_a_d ? rp_a_q[READ_LATENCY-1].data : dout_a_q;
        dout_b_d    = valid_b_d ? rp_b_q[READ_LATENCY-1].data : dout_b_q;
        collision_d = wr_a & wr_b & (exec_a.addr == exec_b.addr);
    end

    // Read pipeline, output and collision registers. Reset discards in-flight reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rp_a_q[i] <= '0;
                rp_b_q[i] <= '0;
            end
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                rp_a_q[i] <= rp_a_d[i];
                rp_b_q[i] <= rp_b_d[i];
            end
            dout_a_q    <= dout_a_d;
            dout_b_q    <= dout_b_d;
            valid_a_q   <= valid_a_d;
            valid_b_q   <= valid_b_d;
            collision_q <= collision_d;
        end
    end

    assign o_dout_a    = dout_a_q;
    assign o_valid_a   = valid_a_q;
    assign o_dout_b    = dout_b_q;
    assign o_valid_b   = valid_b_q;
    assign o_collision = collision_q;

endmodule
